// File: rtl/heap_arbiter_if.sv
// Bus bundle between GPU requesters, the heap port-B arbiter and heap memory port B.
// The master side is the requesters plus memory; the slave side is the arbiter.
interface heap_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int WORD_BYTES = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*32-1:0]         req_address;
    logic [NUM_REQ*32-1:0]         req_wr_data;
    logic [NUM_REQ*WORD_BYTES-1:0] req_wr_en;
    logic [NUM_REQ-1:0]            req_lock;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [31:0]                   rsp_rd_data;
    logic [31:0]                   mem_address;
    logic [31:0]                   mem_wr_data;
    logic [WORD_BYTES-1:0]         mem_wr_en;
    logic [31:0]                   mem_rd_data;

    modport master (
        output req_valid, req_address, req_wr_data, req_wr_en, req_lock, mem_rd_data,
        input  req_ready, rsp_valid, rsp_rd_data, mem_address, mem_wr_data, mem_wr_en
    );

    modport slave (
        input  req_valid, req_address, req_wr_data, req_wr_en, req_lock, mem_rd_data,
        output req_ready, rsp_valid, rsp_rd_data, mem_address, mem_wr_data, mem_wr_en
    );
endinterface

// File: rtl/heap_arbiter.sv
// Round-robin arbiter sharing heap port B among NUM_REQ GPU requesters, with a
// fixed-latency response tag pipeline. Define HEAP_ARB_LOCK_EN to enable grant locking.
module heap_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WORD_BYTES  = 4,
    parameter int MEM_LATENCY = 1
) (
    input logic           clk,
    input logic           reset,
    heap_arbiter_if.slave bus
);
    localparam int IDW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = 1 + MEM_LATENCY;
    localparam int LAST  = MEM_LATENCY;

    typedef logic [IDW-1:0] id_t;

    id_t                   r_prio;
    logic [31:0]           r_mem_address;
    logic [31:0]           r_mem_wr_data;
    logic [WORD_BYTES-1:0] r_mem_wr_en;
    logic                  r_pipe_valid [DEPTH];
    id_t                   r_pipe_id    [DEPTH];
`ifdef HEAP_ARB_LOCK_EN
    logic                  r_locked;
`endif

    logic [31:0]           w_addr [NUM_REQ];
    logic [31:0]           w_data [NUM_REQ];
    logic [WORD_BYTES-1:0] w_wen  [NUM_REQ];
    logic                  w_found;
    logic                  w_accept;
    id_t                   w_winner;
    id_t                   w_idx;
    id_t                   w_next;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_addr[i] = bus.req_address[32*i +: 32];
            w_data[i] = bus.req_wr_data[32*i +: 32];
            w_wen[i]  = bus.req_wr_en[WORD_BYTES*i +: WORD_BYTES];
        end
    end

    // Winner is the first valid requester at or above r_prio, wrapping around.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        w_found  = 1'b0;
        w_winner = r_prio;
        w_idx    = r_prio;
`ifdef HEAP_ARB_LOCK_EN
        if (r_locked) begin
            w_found = bus.req_valid[r_prio];
        end else
`endif
        begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_idx = id_t'((int'(r_prio) + k) % NUM_REQ);
                if (!w_found && bus.req_valid[w_idx]) begin
                    w_found  = 1'b1;
                    w_winner = w_idx;
                end
            end
        end
    end

    assign w_accept = w_found & ~reset;
    assign w_next   = (w_winner == id_t'(NUM_REQ - 1)) ? '0 : id_t'(w_winner + 1'b1);

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = w_accept && (w_winner == id_t'(i));
            bus.rsp_valid[i] = r_pipe_valid[LAST] && (r_pipe_id[LAST] == id_t'(i));
        end
    end

    assign bus.mem_address = r_mem_address;
    assign bus.mem_wr_data = r_mem_wr_data;
    assign bus.mem_wr_en   = r_mem_wr_en;
    assign bus.rsp_rd_data = bus.mem_rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio        <= '0;
            r_mem_address <= '0;
            r_mem_wr_data <= '0;
            r_mem_wr_en   <= '0;
`ifdef HEAP_ARB_LOCK_EN
            r_locked      <= 1'b0;
`endif
            // NOTE: the tag pipeline is tiny, so ids are reset too and never carry X.
            for (int s = 0; s < DEPTH; s++) begin
                r_pipe_valid[s] <= 1'b0;
                r_pipe_id[s]    <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every stage samples pre-edge values.
            if (w_accept) begin
                r_mem_address <= w_addr[w_winner];
                r_mem_wr_data <= w_data[w_winner];
                r_mem_wr_en   <= w_wen[w_winner];
`ifdef HEAP_ARB_LOCK_EN
                if (bus.req_lock[w_winner]) begin
                    r_locked <= 1'b1;
                    r_prio   <= w_winner;
                end else begin
                    r_locked <= 1'b0;
                    r_prio   <= w_next;
                end
`else
                r_prio <= w_next;
`endif
            end else begin
                r_mem_wr_en <= '0;
            end
            r_pipe_valid[0] <= w_accept;
            r_pipe_id[0]    <= w_winner;
            for (int s = 1; s < DEPTH; s++) begin
                r_pipe_valid[s] <= r_pipe_valid[s-1];
                r_pipe_id[s]    <= r_pipe_id[s-1];
            end
        end
    end
endmodule

// File: tb/tb_heap_arbiter.sv
// Self-checking bench for heap_arbiter: reference round-robin model, memory model and
// a response scoreboard. Lock-order expectations follow HEAP_ARB_LOCK_EN.
module tb_heap_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    heap_arbiter_if #(.NUM_REQ(N), .WORD_BYTES(4)) bus ();

    heap_arbiter #(.NUM_REQ(N), .WORD_BYTES(4), .MEM_LATENCY(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          id;
        bit          is_rd;
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t        rsp_q[$];
    int          grant_log[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          rsp_cnt[N];
    logic [31:0] mem_arr[256];
    logic [31:0] ref_mem[256];

    bit          t_valid[N];
    logic [31:0] t_addr[N];
    logic [31:0] t_data[N];
    logic [3:0]  t_wen[N];
    bit          t_lock[N];
    int          m_prio = 0;
    bit          m_locked = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    end

    // Heap port B model: one-cycle registered read, byte-enabled write.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus.mem_wr_en[b]) mem_arr[bus.mem_address[9:2]][8*b +: 8] <= bus.mem_wr_data[8*b +: 8];
        bus.mem_rd_data <= mem_arr[bus.mem_address[9:2]];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: pops the scoreboard when an entry is due, else expects silence.
    always @(negedge clk) begin
        logic [N-1:0] exp_v;
        bit           chk_d;
        rsp_t         item;
        exp_v = '0;
        chk_d = 0;
        item  = '{id: 0, is_rd: 0, data: 32'h0, due: 0};
        for (int i = 0; i < N; i++) rsp_cnt[i] += int'(bus.rsp_valid[i]);
        if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
            item  = rsp_q.pop_front();
            exp_v = N'(1) << item.id;
            chk_d = item.is_rd;
        end
        checks++;
        if (bus.rsp_valid !== exp_v) begin
            errors++;
            $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_v);
        end
        if (chk_d) begin
            checks++;
            if (bus.rsp_rd_data !== item.data) begin
                errors++;
                $display("FAIL rsp_rd_data req=%0d got=%h exp=%h", item.id, bus.rsp_rd_data, item.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]           = t_valid[i];
            bus.req_lock[i]            = t_lock[i];
            bus.req_address[32*i +: 32] = t_addr[i];
            bus.req_wr_data[32*i +: 32] = t_data[i];
            bus.req_wr_en[4*i +: 4]     = t_wen[i];
        end
    endtask

    function automatic int model_winner();
        int w = -1;
        if (m_locked) begin
            if (t_valid[m_prio]) w = m_prio;
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_prio + k) % N;
                if (w < 0 && t_valid[idx]) w = idx;
            end
        end
        return w;
    endfunction

    // One arbitration cycle: check ready against the model, score the accept, cross the edge.
    task automatic cycle(output int win);
        logic [N-1:0] exp_rdy;
        rsp_t         item;
        drive();
        @(negedge clk);
        win     = model_winner();
        exp_rdy = (win >= 0) ? (N'(1) << win) : '0;
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) grant_log.push_back(i);
        checks++;
        if (bus.req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy);
        end
        if (win >= 0) begin
            item.id    = win;
            item.is_rd = (t_wen[win] == 4'h0);
            item.data  = ref_mem[t_addr[win][9:2]];
            item.due   = cyc + 2;
            rsp_q.push_back(item);
            for (int b = 0; b < 4; b++)
                if (t_wen[win][b]) ref_mem[t_addr[win][9:2]][8*b +: 8] = t_data[win][8*b +: 8];
`ifdef HEAP_ARB_LOCK_EN
            if (t_lock[win]) begin
                m_locked = 1;
                m_prio   = win;
            end else begin
                m_locked = 0;
                m_prio   = (win + 1) % N;
            end
`else
            m_prio = (win + 1) % N;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] we, input bit lk);
        t_valid[i] = 1;
        t_addr[i]  = a;
        t_data[i]  = d;
        t_wen[i]   = we;
        t_lock[i]  = lk;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            t_valid[i] = 0;
            t_lock[i]  = 0;
            t_addr[i]  = 32'h0;
            t_data[i]  = 32'h0;
            t_wen[i]   = 4'h0;
        end
    endtask

    task automatic idle(input int n);
        int w;
        for (int i = 0; i < N; i++) t_valid[i] = 0;
        repeat (n) cycle(w);
    endtask

    task automatic drain(input string name);
        idle(4);
        checks++;
        if (rsp_q.size() != 0) begin
            errors++;
            $display("FAIL %s outstanding responses got=%0d exp=0", name, rsp_q.size());
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        rsp_q.delete();
        m_prio   = 0;
        m_locked = 0;
        clear_reqs();
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_order(input string name, input int exp_q[$]);
        checks++;
        if (grant_log.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s grant count got=%0d exp=%0d", name, grant_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (grant_log[i] != exp_q[i]) begin
                    errors++;
                    $display("FAIL %s grant[%0d] got=%0d exp=%0d", name, i, grant_log[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rsp_q.delete();
        m_prio = 0;
        m_locked = 0;
        clear_reqs();
        for (int i = 0; i < N; i++) set_req(i, 32'h0, 32'h0, 4'h0, 0);
        drive();
        @(posedge clk);
        #1;
        checks += 5;
        if (bus.req_ready !== '0) begin errors++; $display("FAIL reset req_ready got=%b exp=0", bus.req_ready); end
        if (bus.rsp_valid !== '0) begin errors++; $display("FAIL reset rsp_valid got=%b exp=0", bus.rsp_valid); end
        if (bus.mem_wr_en !== 4'h0) begin errors++; $display("FAIL reset mem_wr_en got=%h exp=0", bus.mem_wr_en); end
        if (bus.mem_address !== 32'h0) begin errors++; $display("FAIL reset mem_address got=%h exp=0", bus.mem_address); end
        if (bus.mem_wr_data !== 32'h0) begin errors++; $display("FAIL reset mem_wr_data got=%h exp=0", bus.mem_wr_data); end
        clear_reqs();
        drive();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_single();
        int w;
        int base;
        apply_reset();
        base = rsp_cnt[2];
        set_req(2, 32'h40, 32'hDEADBEEF, 4'hF, 0);
        cycle(w);
        checks += 3;
        if (bus.mem_wr_en !== 4'hF) begin errors++; $display("FAIL single mem_wr_en got=%h exp=f", bus.mem_wr_en); end
        if (bus.mem_address !== 32'h40) begin errors++; $display("FAIL single mem_address got=%h exp=40", bus.mem_address); end
        if (bus.mem_wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single mem_wr_data got=%h exp=deadbeef", bus.mem_wr_data); end
        set_req(2, 32'h40, 32'h0, 4'h0, 0);
        cycle(w);
        t_valid[2] = 0;
        checks++;
        if (bus.mem_wr_en !== 4'h0) begin errors++; $display("FAIL single read mem_wr_en got=%h exp=0", bus.mem_wr_en); end
        drain("single");
        checks++;
        if (rsp_cnt[2] - base != 2) begin
            errors++;
            $display("FAIL single rsp count got=%0d exp=2", rsp_cnt[2] - base);
        end
    endtask

    task automatic test_round_robin();
        int w;
        int exp_q[$] = '{0, 1, 2, 3, 0, 1, 2, 3};
        apply_reset();
        grant_log.delete();
        for (int i = 0; i < N; i++) set_req(i, 32'h100 + 32'(16 * i), 32'hA000_0000 | 32'(i << 8), 4'hF, 0);
        for (int c = 0; c < 8; c++) begin
            cycle(w);
            if (w >= 0) begin
                t_wen[w]  = 4'h0;
                t_data[w] = 32'h0;
            end
        end
        drain("round_robin");
        check_order("round_robin", exp_q);
    endtask

    task automatic test_prio_wrap();
        int w;
        int exp_q[$] = '{3, 1, 2};
        apply_reset();
        set_req(1, 32'h100, 32'h0, 4'h0, 0);
        cycle(w);
        t_valid[1] = 0;
        grant_log.delete();
        set_req(1, 32'h104, 32'h0, 4'h0, 0);
        set_req(3, 32'h130, 32'h0, 4'h0, 0);
        for (int c = 0; c < 2; c++) begin
            cycle(w);
            if (w >= 0) t_valid[w] = 0;
        end
        set_req(1, 32'h110, 32'h0, 4'h0, 0);
        set_req(2, 32'h120, 32'h0, 4'h0, 0);
        set_req(3, 32'h134, 32'h0, 4'h0, 0);
        cycle(w);
        drain("prio_wrap");
        check_order("prio_wrap", exp_q);
    endtask

    task automatic test_reset_mid();
        int w;
        int exp_q[$] = '{0, 2};
        apply_reset();
        set_req(1, 32'h300, 32'h1111_2222, 4'hF, 0);
        cycle(w);
        t_valid[1] = 0;
        set_req(2, 32'h304, 32'h3333_4444, 4'hF, 0);
        cycle(w);
        checks += 2;
        if (bus.rsp_valid !== 4'b0010) begin errors++; $display("FAIL reset_mid pre rsp_valid got=%b exp=0010", bus.rsp_valid); end
        if (bus.mem_wr_en !== 4'hF) begin errors++; $display("FAIL reset_mid pre mem_wr_en got=%h exp=f", bus.mem_wr_en); end
        set_req(0, 32'h100, 32'h0, 4'h0, 0);
        set_req(2, 32'h110, 32'h0, 4'h0, 0);
        drive();
        reset = 1'b1;
        rsp_q.delete();
        m_prio   = 0;
        m_locked = 0;
        #1;
        checks += 3;
        if (bus.rsp_valid !== '0) begin errors++; $display("FAIL reset_mid rsp_valid got=%b exp=0", bus.rsp_valid); end
        if (bus.mem_wr_en !== 4'h0) begin errors++; $display("FAIL reset_mid mem_wr_en got=%h exp=0", bus.mem_wr_en); end
        if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_mid req_ready got=%b exp=0", bus.req_ready); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        grant_log.delete();
        for (int c = 0; c < 2; c++) begin
            cycle(w);
            if (w >= 0) t_valid[w] = 0;
        end
        drain("reset_mid");
        check_order("reset_mid", exp_q);
    endtask

    task automatic test_lock();
        int w;
        bit first = 1;
`ifdef HEAP_ARB_LOCK_EN
        int exp_q[$] = '{1, 1, 2, 0};
`else
        int exp_q[$] = '{1, 2, 0, 1};
`endif
        apply_reset();
        set_req(0, 32'h100, 32'h0, 4'h0, 0);
        cycle(w);
        t_valid[0] = 0;
        grant_log.delete();
        set_req(0, 32'h110, 32'h0, 4'h0, 0);
        set_req(1, 32'h200, 32'h0, 4'h0, 1);
        set_req(2, 32'h120, 32'h0, 4'h0, 0);
        for (int c = 0; c < 8 && grant_log.size() < 4; c++) begin
            cycle(w);
            if (w == 1 && first) begin
                first = 0;
                set_req(1, 32'h200, 32'h5A5A_0001, 4'hF, 0);
            end else if (w >= 0) begin
                t_valid[w] = 0;
                t_lock[w]  = 0;
            end
        end
        drain("lock");
        check_order("lock", exp_q);
    endtask

    initial begin
        clear_reqs();
        drive();
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_prio_wrap();
        test_reset_mid();
        test_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
